// File: rtl/npu_circ_buf_fifo_param_if.sv
// ---------------------------------------------------------------------------
// npu_circ_buf_fifo_param_if
// Bus bundle for the parametrised NPU circular-buffer FIFO.
//
// Signals (direction given from the FIFO's point of view, modport "slave"):
//   flush        in   synchronous clear of buffer contents
//   err_clr      in   synchronous clear of sticky error flags
//   din          in   write data, DATA_W bits
//   wr_en        in   write request
//   rd_en        in   read request (pop acknowledge in FWFT builds)
//   dout         out  read data, DATA_W bits
//   dout_valid   out  dout carries a popped / head word
//   full, empty, almost_full, almost_empty   out  occupancy flags
//   count        out  occupancy 0..DEPTH, ADDR_W+1 bits
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
//
// modport master: producer/consumer side that drives the requests.
// modport slave : the FIFO itself.
// ---------------------------------------------------------------------------
interface npu_circ_buf_fifo_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              err_clr;
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, err_clr, din, wr_en, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, err_clr, din, wr_en, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/npu_circ_buf_fifo_param.sv
// ---------------------------------------------------------------------------
// npu_circ_buf_fifo_param
// Parametrised single-clock circular-buffer FIFO buffering packet/operand
// words between NPU producer and consumer stages.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-low reset
//   bus   npu_circ_buf_fifo_param_if.slave (data, requests, flags, errors)
//
// Parameters:
//   DATA_W     word width
//   ADDR_W     address bits, DEPTH = 2**ADDR_W
//   AF_THRESH  almost_full when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Build option:
//   NPU_FIFO_FWFT_EN  when defined, first-word-fall-through: dout shows the
//                     head word combinationally and rd_en pops it. When not
//                     defined, dout is registered with one cycle read latency
//                     and dout_valid pulses for each accepted read.
// ---------------------------------------------------------------------------
module npu_circ_buf_fifo_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 2**ADDR_W - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    npu_circ_buf_fifo_param_if.slave      bus
);
    localparam int DEPTH = 2**ADDR_W;

    // Threshold constants sized to the count width so compares stay exact.
    localparam logic [ADDR_W:0] AF_LVL  = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL  = AE_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    if (ADDR_W < 2 || AE_THRESH <= 0 || AE_THRESH >= AF_THRESH ||
        AF_THRESH > DEPTH) begin : g_bad_cfg
        $error("npu_circ_buf_fifo_param: illegal ADDR_W/AE_THRESH/AF_THRESH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;
    logic              ov_set;
    logic              un_set;
    logic              overflow;
    logic              underflow;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // Acceptance looks only at pre-edge flags; flush masks both requests
    // and also suppresses any error they would otherwise raise.
    assign wr_acc = bus.wr_en && !full  && !bus.flush;
    assign rd_acc = bus.rd_en && !empty && !bus.flush;
    assign ov_set = bus.wr_en && full  && !bus.flush;
    assign un_set = bus.rd_en && empty && !bus.flush;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ov_set || (overflow  && !bus.err_clr);
            underflow <= un_set || (underflow && !bus.err_clr);
        end
    end

`ifdef NPU_FIFO_FWFT_EN
    // Head word falls through; forced to zero while nothing is stored.
    assign bus.dout       = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
    assign bus.dout_valid = !empty;
`else
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;

    // dout holds its last value unless a read is accepted, including on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_acc;
            if (rd_acc) begin
                dout_q <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
`endif

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_LVL);
    assign bus.almost_empty = (count <= AE_LVL);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule
